// File: rtl/four_bank_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// four-bank memory responder (slave).
interface four_bank_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic        createdump;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd, createdump,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd, createdump,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/four_bank_mem_responder.sv
// Four-bank word-interleaved memory responder: per-bank occupancy counters,
// same-cycle accept/stall/err decode and a fixed two-stage read pipeline.
module four_bank_mem_responder #(
    parameter int WORD_AW     = 12,
    parameter int BANK_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    four_bank_mem_responder_if.slave  mem
);
    localparam int         DEPTH    = 1 << WORD_AW;
    localparam logic [2:0] CNT_LOAD = 3'(BANK_CYCLES - 1);

    logic               w_req;
    logic               w_err;
    logic               w_stall;
    logic               w_accept;
    logic [1:0]         w_bank;
    logic [3:0]         w_busy;
    logic [WORD_AW-1:0] w_index;
    logic [15:0]        w_rd_word;
    logic               w_unused;

    logic [2:0]         r_cnt [4];
    logic [15:0]        r_mem [DEPTH];
    logic               r_s1_valid;
    logic [15:0]        r_s1_data;
    logic               r_s2_valid;
    logic [15:0]        r_s2_data;

    assign w_bank  = mem.addr[2:1];
    assign w_index = mem.addr[WORD_AW:1];

    // err outranks stall so an illegal request to a busy bank is reported as illegal.
    assign w_req    = mem.rd | mem.wr;
    assign w_err    = w_req & ((mem.rd & mem.wr) | mem.addr[0]);
    assign w_stall  = w_req & ~w_err & w_busy[w_bank];
    assign w_accept = w_req & ~w_err & ~w_stall;

    // NOTE: assign a default before the loop so no bit of w_busy can infer a latch.
    always_comb begin
        w_busy = '0;
        for (int b = 0; b < 4; b++) begin
            w_busy[b] = (r_cnt[b] != 3'd0);
        end
    end

    // A busy bank cannot accept, so load and decrement never collide on one counter.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt[b] <= CNT_LOAD;
                end else if (r_cnt[b] != 3'd0) begin
                    r_cnt[b] <= r_cnt[b] - 3'd1;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (w_accept && mem.wr) begin
            r_mem[w_index] <= mem.data_in;
        end
    end

    // Read sees the pre-write word; a read and a write never share a cycle.
    assign w_rd_word = r_mem[w_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= w_accept & mem.rd;
            if (w_accept && mem.rd) begin
                r_s1_data <= w_rd_word;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= r_s1_data;
        end
    end

    assign mem.data_out = r_s2_valid ? r_s2_data : 16'h0000;
    assign mem.stall    = w_stall;
    assign mem.err      = w_err;
    assign mem.busy     = w_busy;

    // createdump and high address bits have no function here.
    assign w_unused = ^{mem.createdump, mem.addr};
endmodule
